// File: rtl/axil2iob_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to IOb bridge.
package axil2iob_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RSP  = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_RSP  = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // States in which the IOb slave is being waited on and the timeout runs.
  function automatic logic is_timed(input state_t s);
    return (s == ST_WR_REQ) || (s == ST_RD_REQ) || (s == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/axil2iob_bridge_tmr.sv
// Saturating timeout counter; expired_o is high once the count reaches all-ones.
module axil2iob_bridge_tmr #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT_W == 0) begin : g_off
    logic unused_tmr;
    assign unused_tmr = ^{clk_i, rst_i, clr_i, en_i};
    assign expired_o  = 1'b0;
  end else begin : g_cnt
    logic [TIMEOUT_W-1:0] cnt;

    // Count cycles spent waiting; clear restarts on every state entry
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        cnt <= '0;
      end else if (en_i && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign expired_o = (cnt == '1);
  end

endmodule

// File: rtl/axil2iob_bridge.sv
// Registered AXI4-Lite slave to IOb master bridge, one transaction in flight.
//
// state      | meaning
// IDLE       | waiting for a registered AW+W or AR handshake
// WR_REQ     | IOb write request (avalid) until ready or timeout
// WR_RSP     | bvalid held until bready
// RD_REQ     | IOb read request (avalid, wstrb=0) until ready or timeout
// RD_WAIT    | waiting for iob_rvalid_i or timeout
// RD_RSP     | rvalid held until rready
module axil2iob_bridge
  import axil2iob_bridge_pkg::*;
#(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
  input  logic [2:0]               axil_awprot_i,
  input  logic                     axil_awvalid_i,
  output logic                     axil_awready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
  input  logic                     axil_wvalid_i,
  output logic                     axil_wready_o,
  output logic [1:0]               axil_bresp_o,
  output logic                     axil_bvalid_o,
  input  logic                     axil_bready_i,
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
  input  logic [2:0]               axil_arprot_i,
  input  logic                     axil_arvalid_i,
  output logic                     axil_arready_o,
  output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]               axil_rresp_o,
  output logic                     axil_rvalid_o,
  input  logic                     axil_rready_i,
  output logic                     iob_avalid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic                     iob_rvalid_i,
  input  logic [DATA_W-1:0]        iob_rdata_i,
  input  logic                     iob_ready_i
);

  state_t              state, state_next;
  logic                expired, avalid;
  logic                wr_pend, rd_pend, grant_wr, grant_rd;
  logic                aw_ready, ar_ready, last_rd;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]          bresp, rresp;
  logic                unused_in;

  assign unused_in = ^{axil_awprot_i, axil_arprot_i, axil_awaddr_i, axil_araddr_i};

  axil2iob_bridge_tmr #(.TIMEOUT_W(TIMEOUT_W)) u_tmr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_next != state),
    .en_i     (is_timed(state)),
    .expired_o(expired)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; timeout wins over a same-cycle slave response
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (aw_ready) state_next = ST_WR_REQ;
                  else if (ar_ready) state_next = ST_RD_REQ;
      ST_WR_REQ:  if (expired || iob_ready_i) state_next = ST_WR_RSP;
      ST_RD_REQ:  if (expired) state_next = ST_RD_RSP;
                  else if (iob_ready_i) state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (expired || iob_rvalid_i) state_next = ST_RD_RSP;
      ST_WR_RSP:  if (axil_bready_i) state_next = ST_IDLE;
      ST_RD_RSP:  if (axil_rready_i) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Round-robin: the side not served last wins a tie
  assign wr_pend  = axil_awvalid_i & axil_wvalid_i;
  assign rd_pend  = axil_arvalid_i;
  assign grant_wr = wr_pend & (~rd_pend | last_rd);
  assign grant_rd = rd_pend & (~wr_pend | ~last_rd);

  // Readies are registered one cycle ahead (valids must hold until accepted),
  // so the handshake lands in the first IDLE cycle without an input-to-output path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_ready <= 1'b0;
      ar_ready <= 1'b0;
      last_rd  <= 1'b1;
      addr     <= '0;
      wdata    <= '0;
      wstrb    <= '0;
      bresp    <= AXI_RESP_OKAY;
      rresp    <= AXI_RESP_OKAY;
      rdata    <= '0;
    end else begin
      aw_ready <= (state_next == ST_IDLE) && grant_wr;
      ar_ready <= (state_next == ST_IDLE) && grant_rd;
      if (state == ST_IDLE && aw_ready) begin
        addr    <= axil_awaddr_i[ADDR_W-1:0];
        wdata   <= axil_wdata_i;
        wstrb   <= axil_wstrb_i;
        last_rd <= 1'b0;
      end else if (state == ST_IDLE && ar_ready) begin
        addr    <= axil_araddr_i[ADDR_W-1:0];
        wdata   <= '0;
        wstrb   <= '0;
        last_rd <= 1'b1;
      end
      if (state == ST_WR_REQ && state_next == ST_WR_RSP) begin
        bresp <= expired ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if ((state == ST_RD_REQ || state == ST_RD_WAIT) && state_next == ST_RD_RSP) begin
        rresp <= expired ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rdata <= expired ? '0 : iob_rdata_i;
      end
    end
  end

  assign avalid = (state == ST_WR_REQ || state == ST_RD_REQ) && !expired;

  assign axil_awready_o = aw_ready;
  assign axil_wready_o  = aw_ready;
  assign axil_arready_o = ar_ready;
  assign axil_bvalid_o  = (state == ST_WR_RSP);
  assign axil_bresp_o   = bresp;
  assign axil_rvalid_o  = (state == ST_RD_RSP);
  assign axil_rresp_o   = rresp;
  assign axil_rdata_o   = rdata;
  assign iob_avalid_o   = avalid;
  assign iob_addr_o     = avalid ? addr  : '0;
  assign iob_wdata_o    = avalid ? wdata : '0;
  assign iob_wstrb_o    = avalid ? wstrb : '0;

endmodule

// File: tb/tb_axil2iob_bridge.sv
// Bench for axil2iob_bridge: directed steps plus randomized transactions against a memory model.
module tb_axil2iob_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [20:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        iob_avalid, iob_rvalid, iob_ready;
  logic [20:0] iob_addr;
  logic [31:0] iob_wdata, iob_rdata;
  logic [3:0]  iob_wstrb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // IOb slave model configuration and log
  int          rdy_lat = 0, rd_lat = 1, av_cnt = 0, wait_cnt = 0, rd_cnt = 0, zero_viol = 0;
  bit          mute = 0, stray_rv = 0;
  logic [31:0] rd_val = 0;
  logic [20:0] log_addr = 0;
  logic [31:0] log_wdata = 0;
  logic [3:0]  log_wstrb = 0;

  logic [31:0] ref_mem [logic [20:0]];
  logic [31:0] slv_mem [logic [20:0]];

  axil2iob_bridge #(.TIMEOUT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .axil_awaddr_i(awaddr), .axil_awprot_i(awprot), .axil_awvalid_i(awvalid), .axil_awready_o(awready),
    .axil_wdata_i(wdata), .axil_wstrb_i(wstrb), .axil_wvalid_i(wvalid), .axil_wready_o(wready),
    .axil_bresp_o(bresp), .axil_bvalid_o(bvalid), .axil_bready_i(bready),
    .axil_araddr_i(araddr), .axil_arprot_i(arprot), .axil_arvalid_i(arvalid), .axil_arready_o(arready),
    .axil_rdata_o(rdata), .axil_rresp_o(rresp), .axil_rvalid_o(rvalid), .axil_rready_i(rready),
    .iob_avalid_o(iob_avalid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb),
    .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata), .iob_ready_i(iob_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [20:0] a);
    return {a[10:0], a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(input logic [20:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] slv_get(input logic [20:0] a);
    if (slv_mem.exists(a)) return slv_mem[a];
    return init_val(a);
  endfunction

  // IOb slave: decides ready/rvalid mid-cycle from the registered request
  always @(negedge clk) begin : slave
    logic rv;
    rv = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) rv = 1'b1;
    end
    iob_rvalid = rv | stray_rv;
    iob_rdata  = rv ? rd_val : (stray_rv ? 32'h5A5A5A5A : 32'h0);
    if (iob_avalid) begin
      av_cnt = av_cnt + 1;
      if (!mute && wait_cnt >= rdy_lat) begin
        iob_ready = 1'b1;
        wait_cnt  = 0;
        log_addr  = iob_addr;
        log_wdata = iob_wdata;
        log_wstrb = iob_wstrb;
        if (iob_wstrb != 4'h0) begin
          slv_mem[iob_addr] = merge(slv_get(iob_addr), iob_wdata, iob_wstrb);
        end else begin
          rd_val = slv_get(iob_addr);
          rd_cnt = rd_lat;
        end
      end else begin
        iob_ready = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      iob_ready = 1'b0;
      wait_cnt  = 0;
      if ({iob_addr, iob_wdata, iob_wstrb} != '0) zero_viol = zero_viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [98:0] all_out();
    return {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
            iob_avalid, iob_addr, iob_wdata, iob_wstrb};
  endfunction

  // One AXI transaction with slave latency L/R, optional mute slave (timeout),
  // response backpressure bd, W lagging AW by wd, optional AR queued during the hold.
  task automatic txn(input bit wr, input logic [20:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int L, input int R, input bit m, input int bd, input int wd,
                     input bit hold_ar, input logic [20:0] har);
    int c0, crsp, exp_lat, exp_av;
    bit seen;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    rdy_lat = L; rd_lat = R; mute = m; av_cnt = 0;
    exp_resp = m ? 2'b10 : 2'b00;
    exp_lat  = m ? 17 : (wr ? 2 + L : 2 + L + R);
    exp_av   = m ? 15 : L + 1;
    exp_rd   = 32'h0;
    if (wr) begin
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = (wd == 0);
    end else begin
      araddr = a; arvalid = 1'b1;
      exp_rd = m ? 32'h0 : ref_get(a);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wr && i < wd) chk("aw_without_w", {awready, wready, iob_avalid}, 3'b000);
      if (wr ? awready : arready) begin seen = 1'b1; break; end
      tick;
      if (wr && i + 1 >= wd) wvalid = 1'b1;
    end
    chk("accept_seen", seen, 1'b1);
    if (wr) chk("wready_with_awready", wready, 1'b1);
    c0 = cyc;
    if (wr && !m) ref_mem[a] = merge(ref_get(a), d, s);
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (wr ? bvalid : rvalid) begin seen = 1'b1; break; end
      tick;
    end
    chk("rsp_seen", seen, 1'b1);
    crsp = cyc;
    chk("rsp_latency", crsp - c0, exp_lat);
    chk("resp_code", wr ? bresp : rresp, exp_resp);
    if (!wr) chk("rdata", rdata, exp_rd);
    if (hold_ar) begin araddr = har; arvalid = 1'b1; end
    for (int i = 0; i < bd; i++) begin
      tick;
      if (wr) chk("b_hold", {bvalid, bresp, arready, awready, iob_avalid}, {1'b1, exp_resp, 3'b000});
      else    chk("r_hold", {rvalid, rresp, rdata, arready, awready, iob_avalid}, {1'b1, exp_resp, exp_rd, 3'b000});
    end
    if (wr) bready = 1'b1; else rready = 1'b1;
    tick;
    bready = 1'b0; rready = 1'b0;
    chk("avalid_cycles", av_cnt, exp_av);
    if (!m) begin
      chk("iob_addr", log_addr, a);
      chk("iob_wstrb", log_wstrb, wr ? s : 4'h0);
      if (wr) chk("iob_wdata", log_wdata, d);
    end
  endtask

  // Simultaneous write and read to the same address; write must be served first.
  task automatic pair(input logic [20:0] a, input logic [31:0] d);
    int order[$];
    bit b_done, r_done, aw_on, ar_on, dr_aw, dr_ar;
    int both;
    logic [31:0] got;
    rdy_lat = 0; rd_lat = 1; mute = 0;
    awaddr = a; wdata = d; wstrb = 4'hF; araddr = a;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    aw_on = 1'b1; ar_on = 1'b1; b_done = 1'b0; r_done = 1'b0; both = 0; got = 32'h0;
    for (int i = 0; i < 60 && !(b_done && r_done); i++) begin
      dr_aw = 1'b0; dr_ar = 1'b0;
      if (awready && arready) both++;
      if (aw_on && awready) begin order.push_back(1); dr_aw = 1'b1; end
      if (ar_on && arready) begin order.push_back(2); dr_ar = 1'b1; end
      bready = bvalid; rready = rvalid;
      if (bvalid) b_done = 1'b1;
      if (rvalid) begin r_done = 1'b1; got = rdata; end
      tick;
      bready = 1'b0; rready = 1'b0;
      if (dr_aw) begin aw_on = 1'b0; awvalid = 1'b0; wvalid = 1'b0; end
      if (dr_ar) begin ar_on = 1'b0; arvalid = 1'b0; end
    end
    ref_mem[a] = d;
    chk("pair_done", {b_done, r_done}, 2'b11);
    chk("pair_count", order.size(), 2);
    if (order.size() == 2) chk("pair_write_first", order[0], 1);
    chk("pair_no_dual_ready", both, 0);
    chk("pair_read_data", got, d);
  endtask

  // Watchdog
  initial begin
    wait (cyc > 40000);
    $display("FAIL watchdog cycles=%0d limit=40000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] pool [4];
    int viol;
    bit wr, m;
    pool[0] = 21'h000010; pool[1] = 21'h000020; pool[2] = 21'h000040; pool[3] = 21'h1FFFFC;
    rst_i = 1'b1;
    awaddr = '0; awprot = 3'b101; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b0;
    iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = '0;
    ref_mem[21'h20] = 32'hCAFEF00D;
    slv_mem[21'h20] = 32'hCAFEF00D;
    tick; tick;
    chk("reset_outputs", all_out(), 99'd0);
    rst_i = 1'b0;
    tick;
    chk("idle_outputs", all_out(), 99'd0);

    // Write and read pending together straight out of reset, twice
    pair(21'h40, 32'h11223344);
    pair(21'h40, 32'h55667788);

    // Basic write and read
    txn(1'b1, 21'h10, 32'hDEADBEEF, 4'hF, 0, 1, 1'b0, 0, 0, 1'b0, '0);
    txn(1'b0, 21'h20, 32'h0, 4'h0, 0, 1, 1'b0, 0, 0, 1'b0, '0);

    // AW arrives 5 cycles ahead of W
    txn(1'b1, 21'h10, 32'h0BADF00D, 4'h3, 0, 1, 1'b0, 0, 5, 1'b0, '0);
    txn(1'b0, 21'h10, 32'h0, 4'h0, 1, 2, 1'b0, 0, 0, 1'b0, '0);

    // bready low 10 cycles with a read waiting behind it
    txn(1'b1, 21'h30, 32'h12345678, 4'b0101, 1, 1, 1'b0, 10, 0, 1'b1, 21'h30);
    txn(1'b0, 21'h30, 32'h0, 4'h0, 0, 1, 1'b0, 0, 0, 1'b0, '0);

    // Timeouts: read and write against a slave that never answers
    txn(1'b0, 21'h20, 32'h0, 4'h0, 0, 1, 1'b1, 0, 0, 1'b0, '0);
    stray_rv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stray_rvalid_ignored", {rvalid, rdata, arready, bvalid, iob_avalid}, 36'd0);
    end
    stray_rv = 1'b0;
    tick;
    txn(1'b1, 21'h44, 32'hFFFFFFFF, 4'hF, 0, 1, 1'b1, 2, 0, 1'b0, '0);
    txn(1'b0, 21'h44, 32'h0, 4'h0, 0, 1, 1'b0, 0, 0, 1'b0, '0);
    txn(1'b0, 21'h20, 32'h0, 4'h0, 2, 3, 1'b0, 1, 0, 1'b0, '0);

    // Reset while waiting for read data
    rdy_lat = 0; rd_lat = 6; mute = 1'b0;
    araddr = 21'h20; arvalid = 1'b1;
    for (int i = 0; i < 10 && !arready; i++) tick;
    chk("rst_test_accept", arready, 1'b1);
    tick;
    arvalid = 1'b0;
    chk("rst_test_req", iob_avalid, 1'b1);
    tick;
    chk("rst_test_wait", {iob_avalid, rvalid}, 2'b00);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("rst_mid_read_outputs", all_out(), 99'd0);
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if ({rvalid, arready, iob_avalid, bvalid} != 4'b0000) viol++;
    end
    chk("rst_late_rvalid_ignored", viol, 0);
    pair(21'h40, 32'h9ABCDEF0);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      m  = ($urandom_range(0, 9) == 0);
      txn(wr, pool[$urandom_range(0, 3)], $urandom, 4'($urandom_range(1, 15)),
          $urandom_range(0, 3), $urandom_range(1, 3), m, $urandom_range(0, 2),
          wr ? $urandom_range(0, 2) : 0, 1'b0, '0);
    end

    chk("iob_zero_when_idle", zero_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
